// File: rtl/cgra_pkg.sv
// Shared CGRA types and constants for the column sequencer.
// Contents: config-memory geometry, counter width, sequencer FSM state type.
package cgra_pkg;

    localparam int RCS_NUM_CREG      = 16;
    localparam int RCS_NUM_CREG_LOG2 = 4;
    localparam int SEQ_CNT_WIDTH     = 32;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_CLR,
        SEQ_FETCH,
        SEQ_EXEC,
        SEQ_DONE
    } seq_state_t;

endpackage

// File: rtl/cgra_col_sequencer_if.sv
// Array-side bundle of the column sequencer.
// master: sequencer (drives rst_col/conf_re/pc/pc_en); slave: RC array.
interface cgra_col_sequencer_if;
    import cgra_pkg::*;

    logic                         stall_i;
    logic                         br_req_i;
    logic [RCS_NUM_CREG_LOG2-1:0] br_add_i;
    logic                         exec_end_i;
    logic                         rst_col_o;
    logic                         conf_re_o;
    logic [RCS_NUM_CREG_LOG2-1:0] pc_o;
    logic                         pc_en_o;

    modport master (
        input  stall_i,
        input  br_req_i,
        input  br_add_i,
        input  exec_end_i,
        output rst_col_o,
        output conf_re_o,
        output pc_o,
        output pc_en_o
    );

    modport slave (
        output stall_i,
        output br_req_i,
        output br_add_i,
        output exec_end_i,
        input  rst_col_o,
        input  conf_re_o,
        input  pc_o,
        input  pc_en_o
    );

endinterface

// File: rtl/cgra_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Ports: clk_i, clr_i, inc_i, cnt_o[W-1:0].
module cgra_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/cgra_col_sequencer.sv
// Per-column program sequencer: clear, fetch, execute, branch/end resolution.
// Ports: clk_i, rst_i, start_i, start_pc_i, abort_i, arr (array bundle),
//        busy_o, done_o, aborted_o, err_o, cycle_cnt_o, stall_cnt_o.
module cgra_col_sequencer
    import cgra_pkg::*;
#(
    parameter int CNT_WIDTH = SEQ_CNT_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [RCS_NUM_CREG_LOG2-1:0] start_pc_i,
    input  logic                         abort_i,
    cgra_col_sequencer_if.master         arr,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         aborted_o,
    output logic                         err_o,
    output logic [CNT_WIDTH-1:0]         cycle_cnt_o,
    output logic [CNT_WIDTH-1:0]         stall_cnt_o
);

    localparam int PW = RCS_NUM_CREG_LOG2;
    localparam logic [PW-1:0] PC_MAX = PW'(RCS_NUM_CREG - 1);

    seq_state_t    state_q;
    logic [PW-1:0] pc_q;
    logic          rst_col_q;
    logic          conf_re_q;
    logic          done_q;
    logic          aborted_q;
    logic          busy_q;
    logic          err_q;

    logic          start_ok;
    logic          kill;
    logic          cnt_clr;
    logic          cyc_inc;
    logic          stl_inc;

    assign start_ok = (state_q == SEQ_IDLE) && start_i;
    assign kill     = (state_q != SEQ_IDLE) && abort_i;

    // Outputs are registered alongside the state transition so that each
    // strobe lines up with the state it belongs to.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= SEQ_IDLE;
            pc_q      <= '0;
            err_q     <= 1'b0;
            rst_col_q <= 1'b0;
            conf_re_q <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rst_col_q <= 1'b0;
            conf_re_q <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (kill) begin
                state_q   <= SEQ_IDLE;
                aborted_q <= 1'b1;
                busy_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    SEQ_IDLE: begin
                        if (start_i) begin
                            pc_q      <= start_pc_i;
                            err_q     <= 1'b0;
                            state_q   <= SEQ_CLR;
                            rst_col_q <= 1'b1;
                            busy_q    <= 1'b1;
                        end
                    end
                    SEQ_CLR: begin
                        state_q   <= SEQ_FETCH;
                        conf_re_q <= 1'b1;
                    end
                    SEQ_FETCH: begin
                        state_q <= SEQ_EXEC;
                    end
                    SEQ_EXEC: begin
                        if (!arr.stall_i) begin
                            // Branch outranks end when both arrive together.
                            if (arr.br_req_i) begin
                                pc_q      <= arr.br_add_i;
                                state_q   <= SEQ_FETCH;
                                conf_re_q <= 1'b1;
                            end else if (arr.exec_end_i) begin
                                state_q <= SEQ_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                if (pc_q == PC_MAX) begin
                                    pc_q  <= '0;
                                    err_q <= 1'b1;
                                end else begin
                                    pc_q <= pc_q + 1'b1;
                                end
                                state_q   <= SEQ_FETCH;
                                conf_re_q <= 1'b1;
                            end
                        end
                    end
                    SEQ_DONE: begin
                        state_q <= SEQ_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= SEQ_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cnt_clr = rst_i || start_ok;
    assign cyc_inc = (state_q == SEQ_FETCH) || (state_q == SEQ_EXEC);
    assign stl_inc = (state_q == SEQ_EXEC) && arr.stall_i;

    cgra_sat_counter #(.W(CNT_WIDTH)) u_cyc_cnt (
        .clk_i (clk_i),
        .clr_i (cnt_clr),
        .inc_i (cyc_inc),
        .cnt_o (cycle_cnt_o)
    );

    cgra_sat_counter #(.W(CNT_WIDTH)) u_stl_cnt (
        .clk_i (clk_i),
        .clr_i (cnt_clr),
        .inc_i (stl_inc),
        .cnt_o (stall_cnt_o)
    );

    // The only combinational output: commit strobe in an unstalled,
    // non-aborted EXEC cycle.
    assign arr.pc_en_o   = (state_q == SEQ_EXEC) && !arr.stall_i && !abort_i;
    assign arr.rst_col_o = rst_col_q;
    assign arr.conf_re_o = conf_re_q;
    assign arr.pc_o      = pc_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign aborted_o     = aborted_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_cgra_col_sequencer.sv
// Self-checking bench for cgra_col_sequencer.
// Kernel-level reference model: per EXEC visit (stalls, action) -> pc trace/counters.
module tb_cgra_col_sequencer;
    import cgra_pkg::*;

    localparam int PW = RCS_NUM_CREG_LOG2;

    logic          clk_i;
    logic          rst_i;
    logic          start_i;
    logic [PW-1:0] start_pc_i;
    logic          abort_i;
    logic          busy_o;
    logic          done_o;
    logic          aborted_o;
    logic          err_o;
    logic [31:0]   cycle_cnt_o;
    logic [31:0]   stall_cnt_o;

    cgra_col_sequencer_if arr_if ();

    cgra_col_sequencer #(.CNT_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .start_pc_i  (start_pc_i),
        .abort_i     (abort_i),
        .arr         (arr_if.master),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .aborted_o   (aborted_o),
        .err_o       (err_o),
        .cycle_cnt_o (cycle_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Per-visit program: stall cycles, action (0 next, 1 branch, 2 end,
    // 3 branch+end), branch target, start-while-busy injection.
    int            v_stall[$];
    int            v_act[$];
    logic [PW-1:0] v_tgt[$];
    bit            v_inj[$];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        arr_if.stall_i    = 1'b0;
        arr_if.br_req_i   = 1'b0;
        arr_if.br_add_i   = '0;
        arr_if.exec_end_i = 1'b0;
        start_i           = 1'b0;
        abort_i           = 1'b0;
    endtask

    task automatic add_visit(input int s, input int a, input int t, input bit j);
        v_stall.push_back(s);
        v_act.push_back(a);
        v_tgt.push_back(PW'(t));
        v_inj.push_back(j);
    endtask

    task automatic clr_prog();
        v_stall.delete();
        v_act.delete();
        v_tgt.delete();
        v_inj.delete();
    endtask

    // Entered and left at a negedge with the DUT idle.
    task automatic run_kernel(input int spc);
        int exp_pc[$];
        int pc;
        int cyc;
        int stl;
        bit e_err;
        pc    = spc;
        cyc   = 0;
        stl   = 0;
        e_err = 0;
        foreach (v_act[i]) begin
            exp_pc.push_back(pc);
            cyc += 2 + v_stall[i];
            stl += v_stall[i];
            if (v_act[i] == 1 || v_act[i] == 3) begin
                pc = int'(v_tgt[i]);
            end else if (v_act[i] == 0) begin
                if (pc == RCS_NUM_CREG - 1) e_err = 1;
                pc = (pc + 1) % RCS_NUM_CREG;
            end
        end

        start_i    = 1'b1;
        start_pc_i = PW'(spc);
        @(negedge clk_i);
        clr_in();
        chk("clr_rst_col", arr_if.rst_col_o, 1);
        chk("clr_conf_re", arr_if.conf_re_o, 0);
        chk("clr_busy", busy_o, 1);
        chk("clr_err", err_o, 0);
        chk("clr_cyc", cycle_cnt_o, 0);
        foreach (v_act[i]) begin
            @(negedge clk_i);
            clr_in();
            chk("fetch_conf_re", arr_if.conf_re_o, 1);
            chk("fetch_pc", arr_if.pc_o, exp_pc[i]);
            chk("fetch_done", done_o, 0);
            chk("fetch_pc_en", arr_if.pc_en_o, 0);
            for (int k = 0; k < v_stall[i]; k++) begin
                @(negedge clk_i);
                arr_if.stall_i = 1'b1;
                start_i        = v_inj[i];
                start_pc_i     = PW'($urandom);
                #1;
                chk("stall_pc_en", arr_if.pc_en_o, 0);
                chk("stall_pc", arr_if.pc_o, exp_pc[i]);
            end
            @(negedge clk_i);
            start_i           = 1'b0;
            arr_if.stall_i    = 1'b0;
            arr_if.br_req_i   = (v_act[i] == 1 || v_act[i] == 3);
            arr_if.exec_end_i = (v_act[i] == 2 || v_act[i] == 3);
            arr_if.br_add_i   = v_tgt[i];
            #1;
            chk("exec_pc_en", arr_if.pc_en_o, 1);
            chk("exec_conf_re", arr_if.conf_re_o, 0);
        end
        @(negedge clk_i);
        clr_in();
        chk("done_pulse", done_o, 1);
        chk("done_busy", busy_o, 1);
        chk("done_pc", arr_if.pc_o, exp_pc[exp_pc.size()-1]);
        @(negedge clk_i);
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);
        chk("idle_cyc", cycle_cnt_o, cyc);
        chk("idle_stl", stall_cnt_o, stl);
        chk("idle_err", err_o, e_err);
        chk("idle_pc", arr_if.pc_o, exp_pc[exp_pc.size()-1]);
    endtask

    initial begin
        clr_in();
        start_pc_i = '0;
        rst_i      = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        chk("rst_busy", busy_o, 0);
        chk("rst_pc", arr_if.pc_o, 0);
        chk("rst_rst_col", arr_if.rst_col_o, 0);
        chk("rst_conf_re", arr_if.conf_re_o, 0);
        chk("rst_cyc", cycle_cnt_o, 0);
        chk("rst_err", err_o, 0);

        // Plain three-word kernel from pc 3.
        clr_prog();
        add_visit(0, 0, 0, 0);
        add_visit(0, 0, 0, 0);
        add_visit(0, 2, 0, 0);
        run_kernel(3);

        // Same with a two-cycle stall in the first EXEC plus a stray start.
        clr_prog();
        add_visit(2, 0, 0, 1);
        add_visit(0, 0, 0, 0);
        add_visit(0, 2, 0, 0);
        run_kernel(3);

        // Branch and end together at pc 4: branch to 1.
        clr_prog();
        add_visit(0, 0, 0, 0);
        add_visit(0, 3, 1, 0);
        add_visit(1, 2, 0, 0);
        run_kernel(3);

        // PC wrap sets err; the following start clears it.
        clr_prog();
        add_visit(0, 0, 0, 0);
        add_visit(0, 2, 0, 0);
        run_kernel(RCS_NUM_CREG - 1);
        clr_prog();
        add_visit(0, 2, 0, 0);
        run_kernel(7);

        // Abort during stalled EXEC.
        start_i    = 1'b1;
        start_pc_i = 4'd5;
        @(negedge clk_i);
        clr_in();
        @(negedge clk_i);
        chk("ab_fetch_pc", arr_if.pc_o, 5);
        @(negedge clk_i);
        arr_if.stall_i = 1'b1;
        #1;
        chk("ab_stall_pc_en", arr_if.pc_en_o, 0);
        @(negedge clk_i);
        abort_i = 1'b1;
        #1;
        chk("ab_kill_pc_en", arr_if.pc_en_o, 0);
        @(negedge clk_i);
        clr_in();
        chk("ab_pulse", aborted_o, 1);
        chk("ab_busy", busy_o, 0);
        chk("ab_done", done_o, 0);
        @(negedge clk_i);
        chk("ab_pulse_end", aborted_o, 0);
        chk("ab_done_end", done_o, 0);

        // Reset mid-EXEC.
        start_i    = 1'b1;
        start_pc_i = 4'd9;
        @(negedge clk_i);
        clr_in();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("mrst_busy", busy_o, 0);
        chk("mrst_pc", arr_if.pc_o, 0);
        chk("mrst_pc_en", arr_if.pc_en_o, 0);
        chk("mrst_aborted", aborted_o, 0);
        chk("mrst_done", done_o, 0);
        chk("mrst_cyc", cycle_cnt_o, 0);
        @(negedge clk_i);
        chk("mrst_idle_rst_col", arr_if.rst_col_o, 0);

        // Randomised kernels.
        for (int r = 0; r < 25; r++) begin
            int nv;
            clr_prog();
            nv = $urandom_range(1, 6);
            for (int i = 0; i < nv; i++) begin
                int s;
                int a;
                int x;
                s = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                x = $urandom_range(0, 9);
                if (i == nv - 1) a = 2;
                else if (x < 2) a = 1;
                else if (x == 2) a = 3;
                else a = 0;
                add_visit(s, a, $urandom_range(0, RCS_NUM_CREG - 1),
                          bit'($urandom_range(0, 1)));
            end
            run_kernel($urandom_range(0, RCS_NUM_CREG - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
